// File: rtl/bird_motion_ctrl.sv
// bird_motion_ctrl
// Per-frame bird motion sequencer. It owns the tap-time counter that drives the
// external displacement lookup, and it latches the launch height on each flap.
// It integrates the returned signed displacement into a clamped screen row. It
// also runs the IDLE/PLAY/FALL/DEAD life-cycle FSM.
//
// Ports:
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   i_frame_tick    one-cycle pulse per video frame
//   i_flap          one-cycle debounced button pulse
//   i_start         one-cycle start/restart pulse
//   i_pipe_hit      collision level from the pipe detector
//   i_bird_go_up    signed displacement from the lookup (up = positive)
//   o_bird_tap_time frames since the last flap; feeds the lookup
//   o_bird_y        registered bird screen row (0 = top)
//   o_game_state    0 IDLE, 1 PLAY, 2 FALL, 3 DEAD
//   o_dead_pulse    one-cycle pulse on entry to DEAD
module bird_motion_ctrl #(
    parameter int unsigned START_Y  = 200,
    parameter int unsigned GROUND_Y = 400,
    parameter int unsigned CEIL_Y   = 0,
    parameter int unsigned TAP_MAX  = 127
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_frame_tick,
    input  logic               i_flap,
    input  logic               i_start,
    input  logic               i_pipe_hit,
    input  logic signed [12:0] i_bird_go_up,
    output logic        [12:0] o_bird_tap_time,
    output logic        [9:0]  o_bird_y,
    output logic        [1:0]  o_game_state,
    output logic               o_dead_pulse
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StFall = 2'd2,
        StDead = 2'd3
    } state_e;

    localparam logic        [9:0]  START_Y_V  = 10'(START_Y);
    localparam logic        [9:0]  GROUND_Y_V = 10'(GROUND_Y);
    localparam logic signed [13:0] CEIL_S     = 14'(CEIL_Y);
    localparam logic signed [13:0] GROUND_S   = 14'(GROUND_Y);
    localparam logic        [12:0] TAP_MAX_V  = 13'(TAP_MAX);

    state_e             r_state,      w_state_nxt;
    logic        [12:0] r_tap,        w_tap_nxt;
    logic        [9:0]  r_base_y,     w_base_y_nxt;
    logic        [9:0]  r_bird_y,     w_bird_y_nxt;
    logic               r_flap_pend,  w_flap_pend_nxt;
    logic               r_dead_pulse, w_dead_pulse_nxt;

    logic               w_ground;
    logic               w_pend_eff;
    logic        [12:0] w_tap_inc;
    logic signed [13:0] w_y_next;
    logic        [9:0]  w_y_clamped;

    // Ground is judged on the registered row, so death lands one cycle later.
    assign w_ground   = ((r_state == StPlay) || (r_state == StFall)) && (r_bird_y == GROUND_Y_V);
    // A flap arriving on the same cycle as the tick is consumed by that tick.
    assign w_pend_eff = r_flap_pend | i_flap;
    assign w_tap_inc  = (r_tap >= TAP_MAX_V) ? TAP_MAX_V : r_tap + 13'd1;
    assign w_y_next   = $signed({4'b0000, r_base_y}) - $signed({i_bird_go_up[12], i_bird_go_up});

    always_comb begin
        w_y_clamped = w_y_next[9:0];
        if (w_y_next < CEIL_S) begin
            w_y_clamped = CEIL_S[9:0];
        end else if (w_y_next > GROUND_S) begin
            w_y_clamped = GROUND_Y_V;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; ground takes priority over pipe_hit.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: if (i_start) w_state_nxt = StPlay;
            StPlay: begin
                if (w_ground) begin
                    w_state_nxt = StDead;
                end else if (i_frame_tick && i_pipe_hit) begin
                    w_state_nxt = StFall;
                end
            end
            StFall: if (w_ground) w_state_nxt = StDead;
            StDead: if (i_start) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        w_tap_nxt        = r_tap;
        w_base_y_nxt     = r_base_y;
        w_bird_y_nxt     = r_bird_y;
        w_flap_pend_nxt  = 1'b0;
        w_dead_pulse_nxt = (w_state_nxt == StDead) && (r_state != StDead);
        unique case (r_state)
            StIdle: begin
                w_tap_nxt       = 13'd0;
                w_base_y_nxt    = START_Y_V;
                w_bird_y_nxt    = START_Y_V;
                // Start arms a flap so the first tick launches the bird.
                w_flap_pend_nxt = i_start;
            end
            StPlay: begin
                if (!w_ground) begin
                    w_bird_y_nxt    = w_y_clamped;
                    w_flap_pend_nxt = w_pend_eff;
                    if (i_frame_tick) begin
                        w_flap_pend_nxt = 1'b0;
                        if (i_pipe_hit) begin
                            w_tap_nxt = w_tap_inc;
                        end else if (w_pend_eff) begin
                            w_base_y_nxt = r_bird_y;
                            w_tap_nxt    = 13'd1;
                        end else begin
                            w_tap_nxt = w_tap_inc;
                        end
                    end
                end
            end
            StFall: begin
                if (!w_ground) begin
                    w_bird_y_nxt = w_y_clamped;
                    if (i_frame_tick) w_tap_nxt = w_tap_inc;
                end
            end
            StDead: begin
                if (i_start) begin
                    w_tap_nxt    = 13'd0;
                    w_base_y_nxt = START_Y_V;
                    w_bird_y_nxt = START_Y_V;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tap        <= 13'd0;
            r_base_y     <= START_Y_V;
            r_bird_y     <= START_Y_V;
            r_flap_pend  <= 1'b0;
            r_dead_pulse <= 1'b0;
        end else begin
            r_tap        <= w_tap_nxt;
            r_base_y     <= w_base_y_nxt;
            r_bird_y     <= w_bird_y_nxt;
            r_flap_pend  <= w_flap_pend_nxt;
            r_dead_pulse <= w_dead_pulse_nxt;
        end
    end

    assign o_bird_tap_time = r_tap;
    assign o_bird_y        = r_bird_y;
    assign o_game_state    = r_state;
    assign o_dead_pulse    = r_dead_pulse;

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// tb_bird_motion_ctrl
// Directed bench for bird_motion_ctrl. A small piecewise-linear lookup stands in
// for the tap-time-to-displacement table and hits the reference trajectory points
// (tap 7 -> 20, tap 14 -> 40, tap 30 -> -4, tap 51 -> -207).
module tb_bird_motion_ctrl;

    logic               clk;
    logic               rst_n;
    logic               frame_tick;
    logic               flap;
    logic               start;
    logic               pipe_hit;
    logic signed [12:0] go_up;
    logic        [12:0] tap_time;
    logic        [9:0]  bird_y;
    logic        [1:0]  game_state;
    logic               dead_pulse;

    int n_checks;
    int n_fail;

    bird_motion_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_frame_tick    (frame_tick),
        .i_flap          (flap),
        .i_start         (start),
        .i_pipe_hit      (pipe_hit),
        .i_bird_go_up    (go_up),
        .o_bird_tap_time (tap_time),
        .o_bird_y        (bird_y),
        .o_game_state    (game_state),
        .o_dead_pulse    (dead_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [12:0] lookup(input logic [12:0] t);
        int ti;
        int v;
        ti = int'(t);
        if (ti <= 14) begin
            v = (40 * ti) / 14;
        end else if (ti <= 30) begin
            v = 40 - (44 * (ti - 14)) / 16;
        end else begin
            v = -4 - (203 * (ti - 30)) / 21;
        end
        return 13'(v);
    endfunction

    always_comb go_up = lookup(tap_time);

    // One-cycle pulse on the chosen inputs, then one settle cycle so bird_y has
    // caught up with any tap_time change before the caller samples.
    task automatic drive(input logic f, input logic t, input logic s);
        @(negedge clk);
        flap       = f;
        frame_tick = t;
        start      = s;
        @(negedge clk);
        flap       = 1'b0;
        frame_tick = 1'b0;
        start      = 1'b0;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset;
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        flap       = 1'b0;
        start      = 1'b0;
        pipe_hit   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++;
        if (game_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want 0", game_state);
        end
        n_checks++;
        if (tap_time !== 13'd0 || bird_y !== 10'd200 || dead_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regs: tap %0d y %0d dp %0b want 0 200 0", tap_time, bird_y, dead_pulse);
        end
    endtask

    task automatic test_launch;
        do_reset();
        drive(1'b0, 1'b0, 1'b1);
        ticks(14);
        n_checks++;
        if (tap_time !== 13'd14 || bird_y !== 10'd160 || game_state !== 2'd1) begin
            n_fail++;
            $display("FAIL launch_14: tap %0d y %0d st %0d want 14 160 1", tap_time, bird_y, game_state);
        end
    endtask

    task automatic test_ground_death;
        do_reset();
        drive(1'b0, 1'b0, 1'b1);
        ticks(30);
        n_checks++;
        if (tap_time !== 13'd30 || bird_y !== 10'd204) begin
            n_fail++;
            $display("FAIL fall_30: tap %0d y %0d want 30 204", tap_time, bird_y);
        end
        ticks(21);
        n_checks++;
        if (tap_time !== 13'd51 || bird_y !== 10'd400 || game_state !== 2'd1) begin
            n_fail++;
            $display("FAIL clamp_ground: tap %0d y %0d st %0d want 51 400 1", tap_time, bird_y, game_state);
        end
        @(negedge clk);
        n_checks++;
        if (game_state !== 2'd3 || dead_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL dead_entry: st %0d dp %0b want 3 1", game_state, dead_pulse);
        end
        @(negedge clk);
        n_checks++;
        if (dead_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL dead_pulse_width: dp %0b want 0", dead_pulse);
        end
        ticks(3);
        drive(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (tap_time !== 13'd51 || bird_y !== 10'd400 || game_state !== 2'd3 || dead_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL dead_frozen: tap %0d y %0d st %0d dp %0b want 51 400 3 0",
                     tap_time, bird_y, game_state, dead_pulse);
        end
    endtask

    task automatic test_flap_and_ceiling;
        do_reset();
        drive(1'b0, 1'b0, 1'b1);
        ticks(14);
        drive(1'b1, 1'b0, 1'b0);   // flap stays pending until the tick
        ticks(1);
        n_checks++;
        if (tap_time !== 13'd1) begin
            n_fail++;
            $display("FAIL flap_restart: tap %0d want 1", tap_time);
        end
        ticks(13);
        n_checks++;
        if (tap_time !== 13'd14 || bird_y !== 10'd120) begin
            n_fail++;
            $display("FAIL flap_height: tap %0d y %0d want 14 120", tap_time, bird_y);
        end
        drive(1'b1, 1'b1, 1'b0);   // same-cycle flap+tick: base 120
        ticks(13);
        drive(1'b1, 1'b1, 1'b0);   // base 80
        ticks(13);
        n_checks++;
        if (bird_y !== 10'd40) begin
            n_fail++;
            $display("FAIL flap_chain: y %0d want 40", bird_y);
        end
        drive(1'b1, 1'b1, 1'b0);   // base 40
        ticks(6);
        n_checks++;
        if (tap_time !== 13'd7 || bird_y !== 10'd20) begin
            n_fail++;
            $display("FAIL pre_ceiling: tap %0d y %0d want 7 20", tap_time, bird_y);
        end
        drive(1'b1, 1'b1, 1'b0);   // base 20
        ticks(13);
        n_checks++;
        if (tap_time !== 13'd14 || bird_y !== 10'd0 || game_state !== 2'd1) begin
            n_fail++;
            $display("FAIL ceiling_clamp: tap %0d y %0d st %0d want 14 0 1", tap_time, bird_y, game_state);
        end
    endtask

    task automatic test_pipe_hit;
        int guard;
        do_reset();
        drive(1'b0, 1'b0, 1'b1);
        ticks(5);
        pipe_hit = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        pipe_hit = 1'b0;
        n_checks++;
        if (game_state !== 2'd2 || tap_time !== 13'd6) begin
            n_fail++;
            $display("FAIL pipe_fall: st %0d tap %0d want 2 6", game_state, tap_time);
        end
        drive(1'b1, 1'b1, 1'b1);   // flap and start both ignored in FALL
        n_checks++;
        if (game_state !== 2'd2 || tap_time !== 13'd7) begin
            n_fail++;
            $display("FAIL fall_advance: st %0d tap %0d want 2 7", game_state, tap_time);
        end
        guard = 0;
        while (game_state !== 2'd3 && guard < 100) begin
            drive(1'b0, 1'b1, 1'b0);
            guard++;
        end
        n_checks++;
        if (game_state !== 2'd3 || tap_time !== 13'd51 || bird_y !== 10'd400) begin
            n_fail++;
            $display("FAIL fall_ground: st %0d tap %0d y %0d want 3 51 400", game_state, tap_time, bird_y);
        end
        drive(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (game_state !== 2'd0 || bird_y !== 10'd200 || tap_time !== 13'd0) begin
            n_fail++;
            $display("FAIL restart_idle: st %0d y %0d tap %0d want 0 200 0", game_state, bird_y, tap_time);
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        drive(1'b0, 1'b0, 1'b1);
        ticks(20);
        n_checks++;
        if (tap_time !== 13'd20 || game_state !== 2'd1) begin
            n_fail++;
            $display("FAIL pre_reset: tap %0d st %0d want 20 1", tap_time, game_state);
        end
        #2 rst_n = 1'b0;   // between edges: no clk edge before the sample
        #1;
        n_checks++;
        if (game_state !== 2'd0 || tap_time !== 13'd0 || bird_y !== 10'd200 || dead_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: st %0d tap %0d y %0d dp %0b want 0 0 200 0",
                     game_state, tap_time, bird_y, dead_pulse);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (game_state !== 2'd0 || tap_time !== 13'd0 || bird_y !== 10'd200) begin
            n_fail++;
            $display("FAIL idle_flap: st %0d tap %0d y %0d want 0 0 200", game_state, tap_time, bird_y);
        end
        drive(1'b0, 1'b0, 1'b1);
        ticks(2);
        n_checks++;
        if (game_state !== 2'd1 || tap_time !== 13'd2 || bird_y !== 10'd195) begin
            n_fail++;
            $display("FAIL relaunch: st %0d tap %0d y %0d want 1 2 195", game_state, tap_time, bird_y);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_launch();
        test_ground_death();
        test_flap_and_ceiling();
        test_pipe_hit();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
